inst_ram_loader: RTL and testbench

Program loader that drives the CPU's instruction-RAM debug write port from a byte stream. It accepts a little-endian header word count followed by instruction words, and writes each word to consecutive instruction-RAM addresses with `debug` asserted. It then releases `debug`, holds the CPU in reset for a fixed number of cycles, and lets it run. It sits between a byte source (UART receiver or testbench) and the CPU's `debug`, `inst_ram_write_*` and `reset` inputs.

---
 rtl/inst_ram_loader.sv | 197 +++++++++++++++++++
 tb/tb_inst_ram_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
// Byte-stream program loader: writes N little-endian words into the CPU instruction RAM, then releases CPU reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_ram_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0,
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned RST_HOLD  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        debug,
   output logic        inst_ram_write_enable,
   output logic [31:0] inst_ram_write_data,
   output logic [31:0] inst_ram_write_address,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_HOLD, S_RUN, S_ERROR
`ifdef LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   // Field order: in_ready, debug, cpu_reset, busy, done, error
   typedef struct packed {
      logic in_ready;
      logic debug;
      logic cpu_reset;
      logic busy;
      logic done;
      logic error;
   } outs_t;

   function automatic outs_t state_outs(input state_t st);
      outs_t o;
      case (st)
         S_IDLE:  o = 6'b001000;
         S_HDR:   o = 6'b111100;
         S_DATA:  o = 6'b111100;
         S_HOLD:  o = 6'b001100;
         S_RUN:   o = 6'b000010;
         S_ERROR: o = 6'b001001;
`ifdef LOADER_CHECKSUM_EN
         S_CSUM:  o = 6'b111100;
`endif
         default: o = 6'b001000;
      endcase
      return o;
   endfunction

`ifdef LOADER_CHECKSUM_EN
   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
   localparam state_t S_TAIL = S_CSUM;
   logic [7:0]  csum_r;
`else
   localparam state_t S_TAIL = S_HOLD;
`endif

   state_t      state_r;
   logic [1:0]  byte_cnt_r;
   logic [23:0] shift_r;
   logic [31:0] count_r;
   logic [31:0] word_idx_r;
   logic [31:0] addr_r;
   logic [31:0] hold_cnt_r;
   logic        fin_r;
   logic        accept_s;
   logic [31:0] assembled_s;

   assign accept_s    = in_valid & in_ready;
   assign assembled_s = {in_data, shift_r};

   // Loader sequencer: state, byte assembly and all registered CPU-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r                <= S_IDLE;
         byte_cnt_r             <= 2'd0;
         shift_r                <= 24'd0;
         count_r                <= 32'd0;
         word_idx_r             <= 32'd0;
         addr_r                 <= ADDR_BASE;
         hold_cnt_r             <= 32'd0;
         fin_r                  <= 1'b0;
         {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_IDLE);
         inst_ram_write_enable  <= 1'b0;
         inst_ram_write_data    <= 32'd0;
         inst_ram_write_address <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_r                 <= 8'd0;
`endif
      end else begin
         inst_ram_write_enable <= 1'b0;
         case (state_r)
            S_IDLE, S_RUN, S_ERROR: begin
               if (start) begin
                  state_r    <= S_HDR;
                  byte_cnt_r <= 2'd0;
                  count_r    <= 32'd0;
                  word_idx_r <= 32'd0;
                  addr_r     <= ADDR_BASE;
                  hold_cnt_r <= 32'd0;
                  fin_r      <= 1'b0;
                  {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_HDR);
`ifdef LOADER_CHECKSUM_EN
                  csum_r     <= 8'd0;
`endif
               end
            end
            S_HDR: begin
               if (accept_s) begin
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  shift_r    <= {in_data, shift_r[23:8]};
`ifdef LOADER_CHECKSUM_EN
                  csum_r     <= csum_fold(csum_r, in_data);
`endif
                  if (byte_cnt_r == 2'd3) begin
                     count_r <= assembled_s;
                     if (assembled_s > MAX_WORDS) begin
                        state_r <= S_ERROR;
                        {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_ERROR);
                     end else if (assembled_s == 32'd0) begin
                        state_r <= S_TAIL;
                        {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_TAIL);
                     end else begin
                        state_r <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               // fin_r marks the strobe cycle of the last word: debug stays high, no more bytes taken
               if (fin_r) begin
                  fin_r   <= 1'b0;
                  state_r <= S_HOLD;
                  {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_HOLD);
               end else if (accept_s) begin
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  shift_r    <= {in_data, shift_r[23:8]};
`ifdef LOADER_CHECKSUM_EN
                  csum_r     <= csum_fold(csum_r, in_data);
`endif
                  if (byte_cnt_r == 2'd3) begin
                     inst_ram_write_enable  <= 1'b1;
                     inst_ram_write_data    <= assembled_s;
                     inst_ram_write_address <= addr_r;
                     addr_r                 <= addr_r + 32'd4;
                     word_idx_r             <= word_idx_r + 32'd1;
                     if (word_idx_r == count_r - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_r <= S_CSUM;
`else
                        fin_r    <= 1'b1;
                        in_ready <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (accept_s) begin
                  if (in_data == csum_r) begin
                     state_r <= S_HOLD;
                     {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_HOLD);
                  end else begin
                     state_r <= S_ERROR;
                     {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_ERROR);
                  end
               end
            end
`endif
            S_HOLD: begin
               if (hold_cnt_r == 32'(RST_HOLD - 1)) begin
                  state_r <= S_RUN;
                  {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_RUN);
               end else begin
                  hold_cnt_r <= hold_cnt_r + 32'd1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               {in_ready, debug, cpu_reset, busy, done, error} <= state_outs(S_IDLE);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Self-checking bench for inst_ram_loader: table-driven loads plus random loads against a word-list model.
module tb_inst_ram_loader;
   localparam logic [31:0] BASE = 32'h0;
   localparam int          MAXW = 1024;
   localparam int          HOLD = 4;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, debug, inst_ram_write_enable, cpu_reset, busy, done, error;
   logic [31:0] inst_ram_write_data, inst_ram_write_address;

   always #5 clk = ~clk;

   inst_ram_loader #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW), .RST_HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .debug(debug), .inst_ram_write_enable(inst_ram_write_enable),
      .inst_ram_write_data(inst_ram_write_data), .inst_ram_write_address(inst_ram_write_address),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        dbg;
      int          cyc;
   } strobe_t;

   typedef struct {
      logic [31:0] n;
      int          gap;
      bit          rand_words;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          exp_err;
      string       name;
   } vec_t;

   strobe_t     got_q[$];
   int          cyc = 0;
   int          dbg_fall = 0;
   int          done_rise = 0;
   logic        prev_debug = 1'b0;
   logic        prev_done = 1'b0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] words_a [0:15];
   logic [7:0]  csum_m;
   vec_t        vecs [0:5];

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe and edge recorder
   always @(negedge clk) begin
      if (inst_ram_write_enable)
         got_q.push_back(strobe_t'{inst_ram_write_address, inst_ram_write_data, debug, cyc});
      if (prev_debug && !debug) dbg_fall <= cyc;
      if (!prev_done && done) done_rise <= cyc;
      prev_debug <= debug;
      prev_done  <= done;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input string what, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s/%s: got %0h required %0h", name, what, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s/timeout: got no response required response within bound", name);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input string name);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         in_valid = ($urandom_range(99) >= gap);
         in_data  = in_valid ? b : 8'($urandom);
         acc      = in_valid && in_ready;
         tick();
      end
      in_valid = 1'b0;
      csum_m   = csum_m ^ b;
      if (!acc) timeout(name);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input string name);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap, name);
   endtask

   task automatic run_load(input logic [31:0] n, input int gap, input bit bad_csum,
                           input bit exp_err, input string name);
      int  nw;
      bit  fin;
      got_q.delete();
      csum_m = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check(name, "start_outs", {busy, debug, in_ready, error, done}, 5'b11100);
      send_word(n, gap, name);
      nw = (n > MAXW) ? 0 : int'(n);
      for (int k = 0; k < nw; k++) send_word(words_a[k], gap, name);
`ifdef LOADER_CHECKSUM_EN
      if (n <= MAXW) send_byte(bad_csum ? ~csum_m : csum_m, gap, name);
`endif
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         fin = done || error;
         if (!fin) tick();
      end
      if (!fin) timeout(name);
      @(negedge clk);
      #1;
      check(name, "strobe_count", got_q.size(), nw);
      for (int k = 0; k < nw && k < got_q.size(); k++) begin
         check(name, "addr", got_q[k].addr, BASE + 32'(4 * k));
         check(name, "data", got_q[k].data, words_a[k]);
         check(name, "debug_at_strobe", got_q[k].dbg, 1'b1);
         if (gap == 0 && k > 0) check(name, "strobe_spacing", got_q[k].cyc - got_q[k-1].cyc, 4);
      end
      check(name, "final_outs", {error, done, cpu_reset, in_ready, debug, busy},
            exp_err ? 6'b101000 : 6'b010000);
      if (!exp_err) check(name, "hold_span", done_rise - dbg_fall, HOLD);
   endtask

   initial begin
      vecs[0] = '{32'd2,    0,  1'b0, 32'h2008_0005, 32'h0000_0000, 1'b0, "n2_dense"};
      vecs[1] = '{32'd2,    60, 1'b0, 32'h2008_0005, 32'h0000_0000, 1'b0, "n2_gappy"};
      vecs[2] = '{32'd0,    0,  1'b0, 32'h0,         32'h0,         1'b0, "n0"};
      vecs[3] = '{32'd1025, 0,  1'b0, 32'h0,         32'h0,         1'b1, "n_over_max"};
      vecs[4] = '{32'd7,    30, 1'b1, 32'h0,         32'h0,         1'b0, "n7_rand"};
      vecs[5] = '{32'd1,    0,  1'b0, 32'h1122_3344, 32'h0,         1'b0, "n1_csum_ok"};

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      tick(); tick(); tick();
      check("reset", "ctrl", {in_ready, debug, inst_ram_write_enable, cpu_reset, busy, done, error}, 7'b0001000);
      check("reset", "data_addr", {inst_ram_write_data, inst_ram_write_address}, 64'd0);
      reset = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 16; k++) words_a[k] = $urandom;
         if (!vecs[v].rand_words) begin
            words_a[0] = vecs[v].w0;
            words_a[1] = vecs[v].w1;
         end
         run_load(vecs[v].n, vecs[v].gap, 1'b0, vecs[v].exp_err, vecs[v].name);
         tick();
      end

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) words_a[k] = $urandom;
         run_load(32'($urandom_range(8, 1)), int'($urandom_range(70, 0)), 1'b0, 1'b0, "random");
         tick();
      end

`ifdef LOADER_CHECKSUM_EN
      words_a[0] = 32'h1122_3344;
      run_load(32'd1, 0, 1'b1, 1'b1, "n1_csum_bad");
      tick();
`endif

      // Reset in the middle of word 3 of a 5-word load, then reload from the base address
      for (int k = 0; k < 16; k++) words_a[k] = $urandom;
      got_q.delete();
      csum_m = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word(32'd5, 0, "mid_reset");
      for (int k = 0; k < 3; k++) send_word(words_a[k], 0, "mid_reset");
      send_byte(words_a[3][7:0], 0, "mid_reset");
      send_byte(words_a[3][15:8], 0, "mid_reset");
      reset = 1'b0;
      tick();
      check("mid_reset", "ctrl", {in_ready, debug, inst_ram_write_enable, cpu_reset, busy, done, error}, 7'b0001000);
      check("mid_reset", "data_addr", {inst_ram_write_data, inst_ram_write_address}, 64'd0);
      check("mid_reset", "strobes_before", got_q.size(), 3);
      reset = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) words_a[k] = $urandom;
      run_load(32'd2, 0, 1'b0, 1'b0, "reload");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
